alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_if.sv | 26 ++
 rtl/alu_op_sequencer.sv | 88 ++++++++
 tb/tb_alu_op_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU-drive and response signals of the ALU op sequencer.
interface alu_op_sequencer_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  REQ_OP;
  logic [31:0] REQ_A;
  logic [31:0] REQ_B;
  logic [2:0]  ALU_OP;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic [31:0] ALU_RESULT;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic [2:0]  RSP_OP;
  logic        ERR;
  logic        BUSY;
  modport slave (
    input  REQ_VALID, REQ_OP, REQ_A, REQ_B, ALU_RESULT, RSP_READY,
    output REQ_READY, ALU_OP, ALU_A, ALU_B, RSP_VALID, RSP_DATA, RSP_OP, ERR, BUSY
  );
  modport master (
    output REQ_VALID, REQ_OP, REQ_A, REQ_B, ALU_RESULT, RSP_READY,
    input  REQ_READY, ALU_OP, ALU_A, ALU_B, RSP_VALID, RSP_DATA, RSP_OP, ERR, BUSY
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: 4-deep request FIFO feeding an IDLE/ISSUE/RESP ALU sequencing FSM.
// Optional ALU_SEQ_ILLEGAL_TRAP_EN: op 3'b111 bypasses the ALU and responds with ERR=1.
module alu_op_sequencer (
  input logic               CLK,
  input logic               RST_N,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t      state_q;
  logic [2:0]  op_mem [4];
  logic [31:0] a_mem [4];
  logic [31:0] b_mem [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  alu_op_q, rsp_op_q, head_op;
  logic [31:0] alu_a_q, alu_b_q, rsp_data_q;
  logic        rsp_valid_q, err_q, push, pop, head_ill;
  assign head_op = op_mem[rd_ptr_q];
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign head_ill = head_op == 3'b111;
`else
  assign head_ill = 1'b0;
`endif
  assign bus.REQ_READY = RST_N && cnt_q != 3'd4;
  assign push = bus.REQ_VALID && bus.REQ_READY;
  assign pop = cnt_q != 3'd0 && (state_q == IDLE || (state_q == RESP && bus.RSP_READY));
  assign cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
  assign bus.ALU_OP = alu_op_q;
  assign bus.ALU_A = alu_a_q;
  assign bus.ALU_B = alu_b_q;
  assign bus.RSP_VALID = RST_N && rsp_valid_q;
  assign bus.RSP_DATA = rsp_data_q;
  assign bus.RSP_OP = rsp_op_q;
  assign bus.ERR = err_q;
  assign bus.BUSY = RST_N && (cnt_q != 3'd0 || state_q != IDLE);
  always_ff @(posedge CLK) begin
    if (push) begin
      op_mem[wr_ptr_q] <= bus.REQ_OP;
      a_mem[wr_ptr_q] <= bus.REQ_A;
      b_mem[wr_ptr_q] <= bus.REQ_B;
    end
  end
  // ALU drive registers are non-zero only while in ISSUE
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q <= 3'd0;
      alu_op_q <= 3'd0;
      alu_a_q <= 32'd0;
      alu_b_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp_op_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      cnt_q <= cnt_d;
      if (state_q == ISSUE) begin
        state_q <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_data_q <= bus.ALU_RESULT;
        rsp_op_q <= alu_op_q;
        err_q <= 1'b0;
        alu_op_q <= 3'd0;
        alu_a_q <= 32'd0;
        alu_b_q <= 32'd0;
      end else if (pop && head_ill) begin
        state_q <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_data_q <= 32'd0;
        rsp_op_q <= 3'b111;
        err_q <= 1'b1;
      end else if (pop) begin
        state_q <= ISSUE;
        rsp_valid_q <= 1'b0;
        alu_op_q <= head_op;
        alu_a_q <= a_mem[rd_ptr_q];
        alu_b_q <= b_mem[rd_ptr_q];
      end else if (state_q == RESP && bus.RSP_READY) begin
        state_q <= IDLE;
        rsp_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench with a behavioural ALU and a negedge response logger.
module tb_alu_op_sequencer;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic saw111 = 1'b0;
  logic [31:0] rq_data[$];
  logic [2:0] rq_op[$];
  logic rq_err[$];
  longint rq_t[$];
  int base;
  alu_op_sequencer_if bus ();
  alu_op_sequencer dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;
  always_comb begin
    case (bus.ALU_OP)
      3'd0: bus.ALU_RESULT = bus.ALU_A + bus.ALU_B;
      3'd1: bus.ALU_RESULT = bus.ALU_A - bus.ALU_B;
      3'd2: bus.ALU_RESULT = bus.ALU_A << bus.ALU_B[4:0];
      3'd3: bus.ALU_RESULT = bus.ALU_A >> bus.ALU_B[4:0];
      3'd4: bus.ALU_RESULT = $signed(bus.ALU_A) >>> bus.ALU_B[4:0];
      3'd5: bus.ALU_RESULT = bus.ALU_A & bus.ALU_B;
      3'd6: bus.ALU_RESULT = bus.ALU_A | bus.ALU_B;
      default: bus.ALU_RESULT = bus.ALU_A ^ bus.ALU_B;
    endcase
  end
  always @(negedge CLK) begin
    if (RST_N && bus.RSP_VALID && bus.RSP_READY) begin
      rq_data.push_back(bus.RSP_DATA);
      rq_op.push_back(bus.RSP_OP);
      rq_err.push_back(bus.ERR);
      rq_t.push_back(longint'($time));
    end
    if (bus.ALU_OP == 3'b111) saw111 = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ok;
    ok = 1'b0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP = op;
    bus.REQ_A = a;
    bus.REQ_B = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = bus.REQ_READY;
      tick();
    end
    bus.REQ_VALID = 1'b0;
    chk("send_accept", {31'd0, ok}, 32'd1);
  endtask
  task automatic wait_rsp(input int n);
    for (int i = 0; i < 300 && rq_data.size() < n; i++) tick();
    chk("rsp_count", rq_data.size(), n);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 50 && !bus.RSP_VALID; i++) tick();
    chk("rsp_valid_wait", {31'd0, bus.RSP_VALID}, 32'd1);
  endtask
  initial begin
    logic [31:0] exp_v [5];
    bus.REQ_VALID = 1'b0;
    bus.REQ_OP = 3'd0;
    bus.REQ_A = 32'd0;
    bus.REQ_B = 32'd0;
    bus.RSP_READY = 1'b0;
    tick();
    #1;
    chk("rst_req_ready", {31'd0, bus.REQ_READY}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.RSP_VALID}, 32'd0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    tick();
    chk("rst_rsp_data", bus.RSP_DATA, 32'd0);
    chk("rst_rsp_op", {29'd0, bus.RSP_OP}, 32'd0);
    chk("rst_err", {31'd0, bus.ERR}, 32'd0);
    chk("rst_alu_a", bus.ALU_A, 32'd0);
    RST_N = 1'b1;
    #1;
    chk("rel_req_ready", {31'd0, bus.REQ_READY}, 32'd1);
    // single add: accepted at edge k, response visible after edge k+2
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP = 3'd0;
    bus.REQ_A = 32'd5;
    bus.REQ_B = 32'd7;
    tick();
    bus.REQ_VALID = 1'b0;
    chk("add_k_valid", {31'd0, bus.RSP_VALID}, 32'd0);
    chk("add_k_busy", {31'd0, bus.BUSY}, 32'd1);
    tick();
    chk("add_issue_a", bus.ALU_A, 32'd5);
    chk("add_issue_b", bus.ALU_B, 32'd7);
    chk("add_k1_valid", {31'd0, bus.RSP_VALID}, 32'd0);
    tick();
    chk("add_k2_valid", {31'd0, bus.RSP_VALID}, 32'd1);
    chk("add_data", bus.RSP_DATA, 32'd12);
    chk("add_op", {29'd0, bus.RSP_OP}, 32'd0);
    chk("add_err", {31'd0, bus.ERR}, 32'd0);
    chk("add_resp_alu_a", bus.ALU_A, 32'd0);
    tick();
    chk("add_hold_valid", {31'd0, bus.RSP_VALID}, 32'd1);
    chk("add_hold_data", bus.RSP_DATA, 32'd12);
    bus.RSP_READY = 1'b1;
    tick();
    bus.RSP_READY = 1'b0;
    chk("add_done_valid", {31'd0, bus.RSP_VALID}, 32'd0);
    chk("add_done_busy", {31'd0, bus.BUSY}, 32'd0);
    // fill: first request moves to ISSUE, the next four fill the FIFO
    base = rq_data.size();
    for (int i = 0; i < 5; i++) send(3'd0, 32'(i * 100 + 1), 32'(i));
    chk("fill_ready_low", {31'd0, bus.REQ_READY}, 32'd0);
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP = 3'd0;
    bus.REQ_A = 32'd501;
    bus.REQ_B = 32'd5;
    tick();
    chk("stall_ready_low", {31'd0, bus.REQ_READY}, 32'd0);
    chk("stall_rsp_valid", {31'd0, bus.RSP_VALID}, 32'd1);
    chk("stall_rsp_data", bus.RSP_DATA, 32'd1);
    bus.RSP_READY = 1'b1;
    send(3'd0, 32'd501, 32'd5);
    wait_rsp(base + 6);
    for (int i = 0; i < 6 && base + i < rq_data.size(); i++) begin
      chk("fill_order", rq_data[base + i], 32'(i * 101 + 1));
      if (i > 0) chk("fill_gap", 32'(rq_t[base + i] - rq_t[base + i - 1]), 32'd20);
    end
    // wrap: ten subs push both pointers around the ring
    base = rq_data.size();
    for (int i = 0; i < 10; i++) send(3'd1, 32'(i + 10), 32'(i));
    wait_rsp(base + 10);
    for (int i = 0; i < 10 && base + i < rq_data.size(); i++) begin
      chk("wrap_data", rq_data[base + i], 32'd10);
      chk("wrap_op", {29'd0, rq_op[base + i]}, 32'd1);
    end
    // shifts and logical ops
    base = rq_data.size();
    exp_v[0] = 32'h0000_0010;
    exp_v[1] = 32'h0000_0010;
    exp_v[2] = 32'hF800_0000;
    exp_v[3] = 32'h0000_F000;
    exp_v[4] = 32'h0000_00FF;
    send(3'd2, 32'h1, 32'd4);
    send(3'd3, 32'h80, 32'd3);
    send(3'd4, 32'h8000_0000, 32'd4);
    send(3'd5, 32'hF0F0, 32'hFF00);
    send(3'd6, 32'h0F, 32'hF0);
    wait_rsp(base + 5);
    for (int i = 0; i < 5 && base + i < rq_data.size(); i++) begin
      chk("mix_data", rq_data[base + i], exp_v[i]);
      chk("mix_op", {29'd0, rq_op[base + i]}, 32'(i + 2));
      chk("mix_err", {31'd0, rq_err[base + i]}, 32'd0);
    end
    // op 3'b111
    bus.RSP_READY = 1'b0;
    send(3'd7, 32'd3, 32'd5);
    wait_valid();
    chk("ill_op", {29'd0, bus.RSP_OP}, 32'd7);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    chk("ill_err", {31'd0, bus.ERR}, 32'd1);
    chk("ill_data", bus.RSP_DATA, 32'd0);
    chk("ill_no_alu111", {31'd0, saw111}, 32'd0);
`else
    chk("ill_err", {31'd0, bus.ERR}, 32'd0);
    chk("ill_data", bus.RSP_DATA, 32'd6);
    chk("ill_alu111", {31'd0, saw111}, 32'd1);
`endif
    bus.RSP_READY = 1'b1;
    tick();
    chk("ill_done_valid", {31'd0, bus.RSP_VALID}, 32'd0);
    // reset while a response is pending and two requests are queued
    bus.RSP_READY = 1'b0;
    send(3'd0, 32'd1, 32'd1);
    send(3'd0, 32'd2, 32'd2);
    send(3'd0, 32'd3, 32'd3);
    wait_valid();
    RST_N = 1'b0;
    #1;
    chk("mid_rst_valid_now", {31'd0, bus.RSP_VALID}, 32'd0);
    chk("mid_rst_ready_now", {31'd0, bus.REQ_READY}, 32'd0);
    tick();
    chk("mid_rst_valid", {31'd0, bus.RSP_VALID}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("mid_rst_data", bus.RSP_DATA, 32'd0);
    RST_N = 1'b1;
    #1;
    chk("mid_rel_ready", {31'd0, bus.REQ_READY}, 32'd1);
    base = rq_data.size();
    bus.RSP_READY = 1'b1;
    repeat (10) tick();
    chk("mid_no_stale", rq_data.size(), base);
    chk("mid_idle_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("mid_idle_valid", {31'd0, bus.RSP_VALID}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
